// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and counter-training helper for the branch predict unit.
package branch_predict_unit_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_MAX   = 2'b11;
    localparam logic [1:0] CNT_MIN   = 2'b00;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
        end
        return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational RV32I conditional-branch compare: func3 plus operands to taken/legal.
module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (func3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 < rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve, mispredict/redirect and 2-bit counter BHT for the RV32I pipeline.
// Optional feature: define BRANCH_PERF_CNT_EN for resolve/mispredict performance counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [XLEN-1:0] fetch_pc_in,
    output logic            pred_taken_out,
    input  logic            ex_valid_in,
    input  logic [XLEN-1:0] ex_pc_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      opcode_6_2_in,
    input  logic [2:0]      func3_in,
    input  logic            pred_taken_in,
    input  logic [XLEN-1:0] target_in,
    input  logic            flush_in,
    output logic            resolve_valid_out,
    output logic            branch_taken_out,
    output logic            mispredict_out,
`ifdef BRANCH_PERF_CNT_EN
    output logic [31:0]     br_count_out,
    output logic [31:0]     mispred_count_out,
`endif
    output logic [XLEN-1:0] redirect_pc_out
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;

    logic            cmp_taken;
    logic            cmp_legal;
    logic            fire;
    logic            train;
    logic            taken_d;
    logic            mispredict_d;
    logic [XLEN-1:0] redirect_d;

    logic            resolve_q;
    logic            taken_q;
    logic            mispredict_q;
    logic [XLEN-1:0] redirect_q;

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc_in[XLEN-1:IDX_W+2], fetch_pc_in[1:0]};

    assign fetch_idx      = fetch_pc_in[IDX_W+1:2];
    assign ex_idx         = ex_pc_in[IDX_W+1:2];
    assign pred_taken_out = bht_q[fetch_idx][1];

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .func3 (func3_in),
        .rs1   (rs1_in),
        .rs2   (rs2_in),
        .taken (cmp_taken),
        .legal (cmp_legal)
    );

    always_comb begin
        fire         = 1'b0;
        train        = 1'b0;
        taken_d      = 1'b0;
        mispredict_d = 1'b0;
        redirect_d   = ex_pc_in + XLEN'(4);
        if (ex_valid_in && !flush_in) begin
            case (opcode_6_2_in)
                OPC_BRANCH: begin
                    fire = 1'b1;
                    // Reserved func3 resolves as not-taken without training or redirecting.
                    if (cmp_legal) begin
                        train        = 1'b1;
                        taken_d      = cmp_taken;
                        mispredict_d = (cmp_taken != pred_taken_in);
                        if (cmp_taken) begin
                            redirect_d = target_in;
                        end
                    end
                end
                OPC_JAL: begin
                    fire         = 1'b1;
                    taken_d      = 1'b1;
                    mispredict_d = !pred_taken_in;
                    redirect_d   = target_in;
                end
                OPC_JALR: begin
                    fire         = 1'b1;
                    taken_d      = 1'b1;
                    mispredict_d = 1'b1;
                    redirect_d   = {target_in[XLEN-1:1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_RESET;
            end
            resolve_q    <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            resolve_q    <= fire;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            if (fire) begin
                redirect_q <= redirect_d;
            end
            if (train) begin
                bht_q[ex_idx] <= cnt_train(bht_q[ex_idx], cmp_taken);
            end
        end
    end

    assign resolve_valid_out = resolve_q;
    assign branch_taken_out  = taken_q;
    assign mispredict_out    = mispredict_q;
    assign redirect_pc_out   = redirect_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (fire) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict_d) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign br_count_out      = br_count_q;
    assign mispred_count_out = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized model check.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        pred_in;
    logic [31:0] target;
    logic        flush;
    logic        resolve;
    logic        taken;
    logic        mispred;
    logic [31:0] redirect;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_count;
    logic [31:0] mp_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          mdl_cnt [64];
    bit          exp_resolve;
    bit          exp_taken;
    bit          exp_mp;
    logic [31:0] exp_redirect;
    logic [31:0] exp_br;
    logic [31:0] exp_mpc;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .XLEN      (32),
        .BHT_DEPTH (64)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .fetch_pc_in       (fetch_pc),
        .pred_taken_out    (pred_taken),
        .ex_valid_in       (ex_valid),
        .ex_pc_in          (ex_pc),
        .rs1_in            (rs1),
        .rs2_in            (rs2),
        .opcode_6_2_in     (opc),
        .func3_in          (f3),
        .pred_taken_in     (pred_in),
        .target_in         (target),
        .flush_in          (flush),
        .resolve_valid_out (resolve),
        .branch_taken_out  (taken),
        .mispredict_out    (mispred),
`ifdef BRANCH_PERF_CNT_EN
        .br_count_out      (br_count),
        .mispred_count_out (mp_count),
`endif
        .redirect_pc_out   (redirect)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic bit mdl_pred(input logic [31:0] pc);
        return mdl_cnt[idx_of(pc)] >= 2;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 64; i++) mdl_cnt[i] = 1;
        exp_resolve  = 0;
        exp_taken    = 0;
        exp_mp       = 0;
        exp_redirect = 32'h0;
        exp_br       = 32'h0;
        exp_mpc      = 32'h0;
    endfunction

    function automatic void model_step(input bit v, input bit fl, input logic [4:0] o,
                                       input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] pc,
                                       input logic [31:0] tgt, input bit p);
        bit     tk;
        bit     legal;
        longint sa, sb, ua, ub;
        int     ix;
        exp_resolve = v && !fl && (o == 5'b11000 || o == 5'b11011 || o == 5'b11001);
        exp_taken   = 0;
        exp_mp      = 0;
        if (!exp_resolve) return;
        exp_br = exp_br + 1;
        if (o == 5'b11000) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = longint'({32'd0, a});
            ub = longint'({32'd0, b});
            legal = 1;
            tk    = 0;
            case (f)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = (sa < sb);
                3'd5: tk = (sa >= sb);
                3'd6: tk = (ua < ub);
                3'd7: tk = (ua >= ub);
                default: legal = 0;
            endcase
            exp_taken    = tk;
            exp_redirect = tk ? tgt : pc + 32'd4;
            if (legal) begin
                exp_mp = (tk != p);
                ix = idx_of(pc);
                if (tk) mdl_cnt[ix] = (mdl_cnt[ix] < 3) ? mdl_cnt[ix] + 1 : 3;
                else    mdl_cnt[ix] = (mdl_cnt[ix] > 0) ? mdl_cnt[ix] - 1 : 0;
            end
        end else if (o == 5'b11011) begin
            exp_taken    = 1;
            exp_mp       = !p;
            exp_redirect = tgt;
        end else begin
            exp_taken    = 1;
            exp_mp       = 1;
            exp_redirect = tgt & 32'hFFFF_FFFE;
        end
        if (exp_mp) exp_mpc = exp_mpc + 1;
    endfunction

    task automatic set_in(input bit v, input bit fl, input logic [4:0] o, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] tgt, input bit p);
        ex_valid = v;
        flush    = fl;
        opc      = o;
        f3       = f;
        rs1      = a;
        rs2      = b;
        ex_pc    = pc;
        target   = tgt;
        pred_in  = p;
        model_step(v, fl, o, f, a, b, pc, tgt, p);
    endtask

    task automatic drive(input bit v, input bit fl, input logic [4:0] o, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit p);
        @(negedge clk);
        set_in(v, fl, o, f, a, b, pc, tgt, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 5'b00000, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 5'b00000, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        mdl_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        fetch_pc = 32'h100;
        set_in(0, 0, 5'b00000, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        mdl_reset();
        #12;
        checks++;
        if ({resolve, taken, mispred, redirect} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {resolve, taken, mispred, redirect});
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if ({br_count, mp_count} !== 64'h0) begin
            failures++;
            $display("FAIL reset_perf got=%h exp=0", {br_count, mp_count});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_pred got=%b exp=0", pred_taken);
        end
    endtask

    task automatic test_beq();
        fetch_pc = 32'h100;
        drive(1, 0, 5'b11000, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 0);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b111, 32'h140}) begin
            failures++;
            $display("FAIL beq_out got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b111, 32'h140});
        end
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL beq_trained_pred got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_compare();
        logic [2:0]  f3s  [4] = '{3'd4, 3'd6, 3'd7, 3'd5};
        logic [31:0] reds [4] = '{32'h80, 32'h24, 32'h80, 32'h24};
        bit          tks  [4] = '{1, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 5'b11000, f3s[i], 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h80, 0);
            step();
            checks++;
            if ({resolve, taken, mispred, redirect} !== {1'b1, tks[i], tks[i], reds[i]}) begin
                failures++;
                $display("FAIL compare_f3_%0d got=%h exp=%h", f3s[i],
                         {resolve, taken, mispred, redirect}, {1'b1, tks[i], tks[i], reds[i]});
            end
        end
    endtask

    task automatic test_saturate();
        bit exp_p [5] = '{1, 1, 1, 1, 0};
        do_reset();
        fetch_pc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            // three taken BNEs, then two not-taken
            if (i < 3) drive(1, 0, 5'b11001 ^ 5'b00001, 3'd1, 32'd1, 32'd2, 32'h200, 32'h280,
                             mdl_pred(32'h200));
            else drive(1, 0, 5'b11000, 3'd1, 32'd7, 32'd7, 32'h200, 32'h280, mdl_pred(32'h200));
            step();
            checks++;
            if (pred_taken !== exp_p[i]) begin
                failures++;
                $display("FAIL saturate_pred_%0d got=%b exp=%b", i, pred_taken, exp_p[i]);
            end
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        fetch_pc = 32'h300;
        repeat (2) begin
            drive(1, 0, 5'b11000, 3'd0, 32'd3, 32'd3, 32'h300, 32'h340, 1);
            step();
        end
        drive(1, 0, 5'b11000, 3'd0, 32'd3, 32'd4, 32'h300, 32'h340, 1);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b101, 32'h304}) begin
            failures++;
            $display("FAIL mispredict_out got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b101, 32'h304});
        end
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL mispredict_pred_10 got=%b exp=1", pred_taken);
        end
        drive(1, 0, 5'b11000, 3'd0, 32'd3, 32'd4, 32'h300, 32'h340, 1);
        step();
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL mispredict_pred_01 got=%b exp=0", pred_taken);
        end
    endtask

    task automatic test_jumps();
        do_reset();
        fetch_pc = 32'h400;
        drive(1, 0, 5'b11001, 3'd0, 32'h0, 32'h0, 32'h400, 32'h1235, 1);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b111, 32'h1234}) begin
            failures++;
            $display("FAIL jalr_out got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b111, 32'h1234});
        end
        drive(1, 0, 5'b11011, 3'd0, 32'h0, 32'h0, 32'h400, 32'h2000, 1);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b110, 32'h2000}) begin
            failures++;
            $display("FAIL jal_pred1_out got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b110, 32'h2000});
        end
        drive(1, 0, 5'b11011, 3'd0, 32'h0, 32'h0, 32'h400, 32'h3000, 0);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b111, 32'h3000}) begin
            failures++;
            $display("FAIL jal_pred0_out got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b111, 32'h3000});
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL jump_no_train got=%b exp=0", pred_taken);
        end
    endtask

    task automatic test_illegal_f3();
        do_reset();
        fetch_pc = 32'h408;
        drive(1, 0, 5'b11000, 3'd0, 32'd9, 32'd9, 32'h408, 32'h500, 0);
        step();
        drive(1, 0, 5'b11000, 3'd2, 32'd9, 32'd9, 32'h408, 32'h500, 1);
        step();
        checks++;
        if ({resolve, taken, mispred} !== 3'b100) begin
            failures++;
            $display("FAIL illegal_f3_out got=%b exp=100", {resolve, taken, mispred});
        end
        drive(1, 0, 5'b11000, 3'd3, 32'd9, 32'd8, 32'h408, 32'h500, 1);
        step();
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL illegal_f3_no_train got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_flush();
        do_reset();
        fetch_pc = 32'h504;
        drive(1, 0, 5'b11011, 3'd0, 32'h0, 32'h0, 32'h500, 32'hABC, 1);
        step();
        drive(1, 1, 5'b11000, 3'd0, 32'd1, 32'd1, 32'h504, 32'h600, 0);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b000, 32'hABC}) begin
            failures++;
            $display("FAIL flush_out got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b000, 32'hABC});
        end
        drive(1, 1, 5'b11000, 3'd0, 32'd1, 32'd1, 32'h504, 32'h600, 0);
        step();
        drive(0, 0, 5'b11000, 3'd0, 32'd1, 32'd1, 32'h504, 32'h600, 0);
        step();
        drive(1, 0, 5'b01100, 3'd0, 32'd1, 32'd1, 32'h504, 32'h600, 0);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect, pred_taken} !== {3'b000, 32'hABC, 1'b0}) begin
            failures++;
            $display("FAIL flush_no_train got=%h exp=%h",
                     {resolve, taken, mispred, redirect, pred_taken}, {3'b000, 32'hABC, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_pc = 32'h10;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1, 0, 5'b11000, 3'd0, 32'd2, 32'd2, 32'h10, 32'h90, 0);
            else drive(1, 0, 5'b11000, 3'd0, 32'd2, 32'd3, 32'h10, 32'h90, 0);
            step();
            checks++;
            if (pred_taken !== mdl_pred(32'h10)) begin
                failures++;
                $display("FAIL b2b_pred_%0d got=%b exp=%b", i, pred_taken, mdl_pred(32'h10));
            end
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final got=%b exp=0", pred_taken);
        end
    endtask

    task automatic test_midreset();
        fetch_pc = 32'h40;
        repeat (2) begin
            drive(1, 0, 5'b11000, 3'd0, 32'd1, 32'd1, 32'h40, 32'h44, 0);
            step();
        end
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        checks++;
        if ({resolve, taken, mispred, redirect, pred_taken} !== 36'h0) begin
            failures++;
            $display("FAIL midreset_async got=%h exp=0",
                     {resolve, taken, mispred, redirect, pred_taken});
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if ({br_count, mp_count} !== 64'h0) begin
            failures++;
            $display("FAIL midreset_perf got=%h exp=0", {br_count, mp_count});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0, 5'b11011, 3'd0, 32'h0, 32'h0, 32'h40, 32'h777, 0);
        step();
        checks++;
        if ({resolve, taken, mispred, redirect} !== {3'b111, 32'h777}) begin
            failures++;
            $display("FAIL first_after_reset got=%h exp=%h", {resolve, taken, mispred, redirect},
                     {3'b111, 32'h777});
        end
    endtask

    task automatic test_random();
        logic [4:0]  o;
        logic [31:0] a, b, pc;
        int          r;
        bit          old_p;
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 9));
            o  = (r < 6) ? 5'b11000 : (r == 6) ? 5'b11011 : (r == 7) ? 5'b11001 : 5'b01100;
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2);
            fetch_pc = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2);
            #1;
            checks++;
            if (pred_taken !== mdl_pred(fetch_pc)) begin
                failures++;
                $display("FAIL rand_pred_new n=%0d got=%b exp=%b", n, pred_taken,
                         mdl_pred(fetch_pc));
            end
            old_p = mdl_pred(fetch_pc);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, o,
                  3'($urandom_range(0, 7)), a, b, pc, $urandom, 1'($urandom_range(0, 1)));
            #1;
            checks++;
            if (pred_taken !== old_p) begin
                failures++;
                $display("FAIL rand_pred_old n=%0d got=%b exp=%b", n, pred_taken, old_p);
            end
            step();
            checks++;
            if ({resolve, taken, mispred, redirect} !==
                {exp_resolve, exp_taken, exp_mp, exp_redirect}) begin
                failures++;
                $display("FAIL rand_out n=%0d got=%h exp=%h", n,
                         {resolve, taken, mispred, redirect},
                         {exp_resolve, exp_taken, exp_mp, exp_redirect});
            end
`ifdef BRANCH_PERF_CNT_EN
            checks++;
            if ({br_count, mp_count} !== {exp_br, exp_mpc}) begin
                failures++;
                $display("FAIL rand_perf n=%0d got=%h exp=%h", n, {br_count, mp_count},
                         {exp_br, exp_mpc});
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_beq();
        test_compare();
        test_saturate();
        test_mispredict();
        test_jumps();
        test_illegal_f3();
        test_flush();
        test_back_to_back();
        test_midreset();
        test_random();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
